// File: rtl/mux_dest_reg.sv
// Registered destination-register selector: picks a data input or a constant code on load,
// keeps the previous destination, and tracks invalid select codes with a sticky flag and a saturating counter.
module mux_dest_reg #(
    parameter int WIDTH   = 5,
    parameter int N_IN    = 3,
    parameter int SEL_W   = 3,
    parameter int CONST_A = 29,
    parameter int CONST_B = 31,
    parameter int CNT_W   = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_IN*WIDTH-1:0]   entradas,
    input  logic [SEL_W-1:0]        controle,
    input  logic                    load,
    input  logic                    limpa_erro,
    output logic [WIDTH-1:0]        saida,
    output logic [WIDTH-1:0]        saida_anterior,
    output logic                    saida_valida,
    output logic                    erro_sel,
    output logic [CNT_W-1:0]        erro_cnt
);

    localparam logic [WIDTH-1:0] VAL_A   = WIDTH'(CONST_A);
    localparam logic [WIDTH-1:0] VAL_B   = WIDTH'(CONST_B);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] saida_q, saida_d;
    logic [WIDTH-1:0] saida_anterior_q, saida_anterior_d;
    logic             saida_valida_q, saida_valida_d;
    logic             erro_sel_q, erro_sel_d;
    logic [CNT_W-1:0] erro_cnt_q, erro_cnt_d;

    logic [WIDTH-1:0] candidato;
    logic             sel_valido;
    logic             load_valido;
    logic             load_invalido;

    always_comb begin
        candidato  = '0;
        sel_valido = (int'(controle) < N_IN + 2);
        for (int i = 0; i < N_IN; i++) begin
            if (int'(controle) == i) candidato = entradas[i*WIDTH +: WIDTH];
        end
        if (int'(controle) == N_IN)     candidato = VAL_A;
        if (int'(controle) == N_IN + 1) candidato = VAL_B;
    end

    assign load_valido   = load && sel_valido;
    assign load_invalido = load && !sel_valido;

    always_comb begin
        saida_d          = saida_q;
        saida_anterior_d = saida_anterior_q;
        saida_valida_d   = 1'b0;
        erro_sel_d       = erro_sel_q;
        erro_cnt_d       = erro_cnt_q;

        if (load_valido) begin
            saida_d          = candidato;
            saida_anterior_d = saida_q;
            saida_valida_d   = 1'b1;
        end

        // A new invalid event outranks a clear in the same cycle.
        if (load_invalido) begin
            erro_sel_d = 1'b1;
            if (limpa_erro)
                erro_cnt_d = CNT_ONE;
            else if (erro_cnt_q != CNT_MAX)
                erro_cnt_d = erro_cnt_q + CNT_ONE;
        end else if (limpa_erro) begin
            erro_sel_d = 1'b0;
            erro_cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            saida_q          <= '0;
            saida_anterior_q <= '0;
            saida_valida_q   <= 1'b0;
            erro_sel_q       <= 1'b0;
            erro_cnt_q       <= '0;
        end else begin
            saida_q          <= saida_d;
            saida_anterior_q <= saida_anterior_d;
            saida_valida_q   <= saida_valida_d;
            erro_sel_q       <= erro_sel_d;
            erro_cnt_q       <= erro_cnt_d;
        end
    end

    assign saida          = saida_q;
    assign saida_anterior = saida_anterior_q;
    assign saida_valida   = saida_valida_q;
    assign erro_sel       = erro_sel_q;
    assign erro_cnt       = erro_cnt_q;

endmodule

// File: tb/tb_mux_dest_reg.sv
// Directed bench for mux_dest_reg: default instance plus a CNT_W=2 instance for saturation.
module tb_mux_dest_reg;

    logic        clock = 1'b0;
    logic        reset;
    logic [14:0] entradas;
    logic [2:0]  controle;
    logic        load;
    logic        limpa_erro;

    logic [4:0]  saida, saida_anterior;
    logic        saida_valida, erro_sel;
    logic [7:0]  erro_cnt;

    logic [4:0]  s2_saida, s2_saida_anterior;
    logic        s2_saida_valida, s2_erro_sel;
    logic [1:0]  s2_erro_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    mux_dest_reg u_dut (
        .clock(clock), .reset(reset), .entradas(entradas), .controle(controle),
        .load(load), .limpa_erro(limpa_erro), .saida(saida),
        .saida_anterior(saida_anterior), .saida_valida(saida_valida),
        .erro_sel(erro_sel), .erro_cnt(erro_cnt)
    );

    mux_dest_reg #(.CNT_W(2)) u_sat (
        .clock(clock), .reset(reset), .entradas(entradas), .controle(controle),
        .load(load), .limpa_erro(limpa_erro), .saida(s2_saida),
        .saida_anterior(s2_saida_anterior), .saida_valida(s2_saida_valida),
        .erro_sel(s2_erro_sel), .erro_cnt(s2_erro_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply inputs, clock one edge, then sample 1 ns later.
    task automatic step(input logic r, input logic l, input logic [2:0] c, input logic le);
        reset = r; load = l; controle = c; limpa_erro = le;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input int s, input int sa, input int v,
                           input int es, input int ec);
        chk({tag, ".saida"},          32'(saida),          32'(s));
        chk({tag, ".saida_anterior"}, 32'(saida_anterior), 32'(sa));
        chk({tag, ".saida_valida"},   32'(saida_valida),   32'(v));
        chk({tag, ".erro_sel"},       32'(erro_sel),       32'(es));
        chk({tag, ".erro_cnt"},       32'(erro_cnt),       32'(ec));
    endtask

    initial begin
        entradas   = {5'd3, 5'd17, 5'd8};
        reset      = 1'b1;
        load       = 1'b0;
        controle   = 3'd0;
        limpa_erro = 1'b0;

        // 1. reset then idle
        step(1, 0, 3'd2, 0); chk_out("rst0", 0, 0, 0, 0, 0);
        step(1, 0, 3'd2, 0); chk_out("rst1", 0, 0, 0, 0, 0);
        step(0, 0, 3'd2, 0); chk_out("idle0", 0, 0, 0, 0, 0);
        step(0, 0, 3'd2, 0); chk_out("idle1", 0, 0, 0, 0, 0);

        // 2. every valid code back to back
        step(0, 1, 3'd0, 0); chk_out("seq0", 8, 0, 1, 0, 0);
        step(0, 1, 3'd1, 0); chk_out("seq1", 17, 8, 1, 0, 0);
        step(0, 1, 3'd2, 0); chk_out("seq2", 3, 17, 1, 0, 0);
        step(0, 1, 3'd3, 0); chk_out("seq3", 29, 3, 1, 0, 0);
        step(0, 1, 3'd4, 0); chk_out("seq4", 31, 29, 1, 0, 0);

        // load=0 holds, ignores an invalid code
        step(0, 0, 3'd6, 0); chk_out("hold", 31, 29, 0, 0, 0);

        // 3. invalid code
        step(0, 1, 3'd6, 0); chk_out("inval", 31, 29, 0, 1, 1);

        // 4. clear race, then plain clear
        step(0, 1, 3'd7, 1); chk_out("race", 31, 29, 0, 1, 1);
        step(0, 0, 3'd0, 1); chk_out("clear", 31, 29, 0, 0, 0);
        chk("sat.clear_cnt", 32'(s2_erro_cnt), 32'd0);

        // 5. saturation on the CNT_W=2 instance; wide instance keeps counting
        step(0, 1, 3'd5, 0); chk("sat1", 32'(s2_erro_cnt), 1); chk("wide1", 32'(erro_cnt), 1);
        step(0, 1, 3'd6, 0); chk("sat2", 32'(s2_erro_cnt), 2); chk("wide2", 32'(erro_cnt), 2);
        step(0, 1, 3'd7, 0); chk("sat3", 32'(s2_erro_cnt), 3); chk("wide3", 32'(erro_cnt), 3);
        step(0, 1, 3'd5, 0); chk("sat4", 32'(s2_erro_cnt), 3); chk("wide4", 32'(erro_cnt), 4);
        step(0, 1, 3'd6, 0); chk("sat5", 32'(s2_erro_cnt), 3); chk("wide5", 32'(erro_cnt), 5);
        chk("sat.erro_sel", 32'(s2_erro_sel), 1);
        chk("sat.saida_hold", 32'(s2_saida), 31);

        // limpa_erro alongside a valid load leaves the datapath alone
        step(0, 1, 3'd3, 1); chk_out("clr_valid", 29, 31, 1, 0, 0);

        // 6. reset priority over load
        step(1, 1, 3'd1, 0); chk_out("rst_prio", 0, 0, 0, 0, 0);
        step(0, 1, 3'd1, 0); chk_out("post_rst", 17, 0, 1, 0, 0);
        step(0, 0, 3'd0, 0); chk_out("post_idle", 17, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
